// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default timing constants and baud settings.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GUARD     = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] ISSUE_TIMEOUT_DEF = 16'd4096;
  localparam logic [CNT_W-1:0] GUARD_CYCLES_DEF  = 16'd16;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned BAUD     = 115_200;
  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with issue timeout and a guard gap between consecutive bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter logic [15:0] ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEF,
  parameter logic [15:0] GUARD_CYCLES  = GUARD_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     timeout_err
);

  localparam int unsigned GW = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    last_q, last_d;
  logic [GW-1:0]    grant_d;
  logic [7:0]       data_d;
  logic [N_REQ-1:0] ack_d;
  logic             start_d;
  logic             tmo_d;
  logic             active_d;
  logic             busy_s;

  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic [7:0]       win_byte;
  logic [7:0]       byte_arr [N_REQ];
  int unsigned      cand;

  bit_sync u_busy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_busy),
    .q     (busy_s)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign byte_arr[g] = req_data[8*g +: 8];
  end

  assign win_byte = byte_arr[win_idx];

  // Rotating priority: search upward from the requester after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[GW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_id;
    data_d  = tx_data;
    ack_d   = '0;
    start_d = 1'b0;
    tmo_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d        = ST_ISSUE;
          cnt_d          = '0;
          last_d         = win_idx;
          grant_d        = win_idx;
          data_d         = win_byte;
          ack_d[win_idx] = 1'b1;
          start_d        = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (busy_s) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == ISSUE_TIMEOUT - 16'd1) begin
          // Byte is dropped; the requester was already acked.
          state_d = ST_GUARD;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          start_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_CYCLES - 16'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= GW'(N_REQ - 1);
      grant_id    <= '0;
      tx_data     <= 8'h00;
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_id    <= grant_d;
      tx_data     <= data_d;
      ack         <= ack_d;
      tx_start    <= start_d;
      timeout_err <= tmo_d;
      active      <= active_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a behavioural transmitter
// and a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned GW   = 2;
  localparam int unsigned TMO  = 4096;
  localparam int unsigned GRD  = 16;
  // Two synchronizer flops plus the registered FSM response.
  localparam int unsigned RESP = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [GW-1:0]  grant_id;
  logic           active;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;
  int last_g = N - 1;
  bit model_en = 1'b1;

  uart_tx_arbiter #(
    .N_REQ         (N),
    .ISSUE_TIMEOUT (16'(TMO)),
    .GUARD_CYCLES  (16'(GRD))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises 3 cycles after tx_start, stays high for 40 cycles.
  int m_phase;
  int m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (tx_start && model_en) begin m_phase <= 1; m_cnt <= 1; end
        1: if (m_cnt == 0) begin tx_busy <= 1'b1; m_phase <= 2; m_cnt <= 39; end
           else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 0) begin tx_busy <= 1'b0; m_phase <= 0; end
                 else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  typedef struct {
    bit           done;
    int           ack_cnt;
    logic [N-1:0] ack_or;
    logic [GW-1:0] gid;
    logic [7:0]   data;
    bit           data_changed;
    int           start_busy;
    int           tail;
    int           tmo_cnt;
    int           tmo_at;
    int           issue_len;
    int           post_tmo;
  } obs_t;

  function automatic int predict(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Follows one grant from ack until the arbiter is idle again, gathering observations.
  task automatic observe(input bit drop, input bit guard_pulse, output obs_t o);
    bit started = 1'b0;
    bit busy_seen = 1'b0;
    bit busy_fell = 1'b0;
    o = '{default: 0};
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        o.ack_cnt++;
        o.ack_or |= ack;
        if (!started) begin o.gid = grant_id; o.data = tx_data; end
        started = 1'b1;
        if (drop) req &= ~ack;
      end
      if (started) begin
        if (tx_data !== o.data) o.data_changed = 1'b1;
        if (tx_start) o.issue_len++;
        if (timeout_err) begin o.tmo_cnt++; o.tmo_at = o.issue_len; end
        if (o.tmo_cnt > 0 && active && !tx_start) o.post_tmo++;
        if (tx_busy) begin
          busy_seen = 1'b1;
          if (tx_start) o.start_busy++;
        end else if (busy_seen) busy_fell = 1'b1;
        if (busy_fell && active) o.tail++;
        if (guard_pulse && busy_fell) begin
          if (o.tail == 5) req[1] = 1'b1;
          else if (o.tail == 8) req[1] = 1'b0;
        end
        if (!active) begin o.done = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL rst_ack got %b want 0", ack); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_err); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", active); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
    rst_n = 1'b1; last_g = N - 1;
    repeat (4) @(negedge clk);
    checks++; if (active !== 1'b0 || ack !== '0 || tx_start !== 1'b0)
      begin errors++; $display("FAIL idle_no_req got active=%b ack=%b start=%b want 0", active, ack, tx_start); end
  endtask

  task automatic test_rotation;
    obs_t o;
    logic [N-1:0] oh;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = '1;
    for (int t = 0; t < 5; t++) begin
      observe(1'b0, 1'b0, o);
      oh = '0; oh[t % N] = 1'b1;
      checks++; if (!o.done) begin errors++; $display("FAIL rot_done[%0d] got 0 want 1", t); end
      checks++; if (o.gid !== GW'(t % N)) begin errors++; $display("FAIL rot_gid[%0d] got %0d want %0d", t, o.gid, t % N); end
      checks++; if (o.ack_or !== oh || o.ack_cnt != 1)
        begin errors++; $display("FAIL rot_ack[%0d] got %b x%0d want %b x1", t, o.ack_or, o.ack_cnt, oh); end
      checks++; if (o.data !== 8'h10 + 8'(t % N)) begin errors++; $display("FAIL rot_data[%0d] got %h want %h", t, o.data, 8'h10 + 8'(t % N)); end
      last_g = t % N;
    end
    req = '0;
  endtask

  task automatic test_wrap;
    obs_t o;
    int want;
    req_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    req = 4'b0010;
    observe(1'b1, 1'b0, o);
    checks++; if (o.gid !== GW'(1)) begin errors++; $display("FAIL wrap_first got %0d want 1", o.gid); end
    last_g = 1;
    req = 4'b0011;
    for (int t = 0; t < 2; t++) begin
      want = (t == 0) ? 0 : 1;
      observe(1'b1, 1'b0, o);
      checks++; if (o.gid !== GW'(want) || o.ack_cnt != 1)
        begin errors++; $display("FAIL wrap_grant[%0d] got %0d x%0d want %0d x1", t, o.gid, o.ack_cnt, want); end
      checks++; if (o.data !== req_data[8*want +: 8]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", t, o.data, req_data[8*want +: 8]); end
      last_g = want;
    end
  endtask

  task automatic test_single;
    obs_t o;
    req_data = {8'($urandom), 8'hA5, 8'($urandom), 8'($urandom)};
    req = 4'b0100;
    observe(1'b1, 1'b0, o);
    checks++; if (!o.done) begin errors++; $display("FAIL single_done got 0 want 1"); end
    checks++; if (o.ack_or !== 4'b0100 || o.ack_cnt != 1)
      begin errors++; $display("FAIL single_ack got %b x%0d want 0100 x1", o.ack_or, o.ack_cnt); end
    checks++; if (o.gid !== GW'(2) || o.data !== 8'hA5 || o.data_changed)
      begin errors++; $display("FAIL single_out got id=%0d data=%h chg=%0d want id=2 data=a5 chg=0", o.gid, o.data, o.data_changed); end
    checks++; if (o.start_busy != RESP) begin errors++; $display("FAIL single_start_hold got %0d want %0d", o.start_busy, RESP); end
    checks++; if (o.tail != RESP + GRD) begin errors++; $display("FAIL single_guard got %0d want %0d", o.tail, RESP + GRD); end
    checks++; if (o.tmo_cnt != 0) begin errors++; $display("FAIL single_no_timeout got %0d want 0", o.tmo_cnt); end
    last_g = 2;
  endtask

  task automatic test_guard_pulse;
    obs_t o;
    int bad = 0;
    req_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'h3C};
    req = 4'b0001;
    observe(1'b1, 1'b1, o);
    last_g = 0;
    checks++; if (o.ack_or !== 4'b0001 || o.ack_cnt != 1)
      begin errors++; $display("FAIL guard_ack got %b x%0d want 0001 x1", o.ack_or, o.ack_cnt); end
    checks++; if (o.data_changed || o.data !== 8'h3C)
      begin errors++; $display("FAIL guard_data got %h chg=%0d want 3c chg=0", o.data, o.data_changed); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack !== '0 || active !== 1'b0 || tx_data !== 8'h3C) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL guard_quiet got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_timeout;
    obs_t o;
    int bad = 0;
    model_en = 1'b0;
    req = 4'b0001;
    observe(1'b1, 1'b0, o);
    last_g = 0;
    checks++; if (!o.done) begin errors++; $display("FAIL tmo_done got 0 want 1"); end
    checks++; if (o.tmo_cnt != 1 || o.ack_cnt != 1)
      begin errors++; $display("FAIL tmo_pulses got tmo=%0d ack=%0d want 1 1", o.tmo_cnt, o.ack_cnt); end
    checks++; if (o.tmo_at != TMO || o.issue_len != TMO)
      begin errors++; $display("FAIL tmo_cycle got at=%0d len=%0d want %0d", o.tmo_at, o.issue_len, TMO); end
    checks++; if (o.post_tmo != GRD) begin errors++; $display("FAIL tmo_guard got %0d want %0d", o.post_tmo, GRD); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ack !== '0 || timeout_err !== 1'b0 || active !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tmo_no_retry got %0d bad cycles want 0", bad); end
    model_en = 1'b1;
  endtask

  task automatic test_random;
    obs_t o;
    int want;
    logic [7:0] want_byte;
    logic [N-1:0] oh;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      if (req == '0) begin
        int i = $urandom_range(0, N - 1);
        req[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        int i = $urandom_range(0, N - 1);
        if (req[i] && $countones(req) > 1) req[i] = 1'b0;
      end
      want = predict(req, last_g);
      want_byte = req_data[8*want +: 8];
      oh = '0; oh[want] = 1'b1;
      observe(1'b1, 1'b0, o);
      checks++; if (!o.done) begin errors++; $display("FAIL rnd_done[%0d] got 0 want 1", it); end
      checks++; if (o.gid !== GW'(want) || o.ack_or !== oh || o.ack_cnt != 1)
        begin errors++; $display("FAIL rnd_grant[%0d] got id=%0d ack=%b x%0d want id=%0d ack=%b x1", it, o.gid, o.ack_or, o.ack_cnt, want, oh); end
      checks++; if (o.data !== want_byte || o.data_changed)
        begin errors++; $display("FAIL rnd_data[%0d] got %h chg=%0d want %h", it, o.data, o.data_changed, want_byte); end
      last_g = want;
    end
    req = '0;
  endtask

  task automatic test_reset_mid;
    obs_t o;
    bit ok = 1'b0;
    int bad = 0;
    req_data[8*2 +: 8] = 8'h5A;
    req = 4'b0100;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack != '0) req &= ~ack;
      if (tx_busy && !tx_start && active) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_reach_wait got 0 want 1"); end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0 || active !== 1'b0)
      begin errors++; $display("FAIL rmid_immediate got start=%b active=%b want 0 0", tx_start, active); end
    checks++; if (ack !== '0 || grant_id !== '0 || tx_data !== 8'h00)
      begin errors++; $display("FAIL rmid_outputs got ack=%b id=%0d data=%h want 0 0 00", ack, grant_id, tx_data); end
    @(negedge clk);
    rst_n = 1'b1;
    last_g = N - 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack !== '0 || active !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_replay got %0d bad cycles want 0", bad); end
    req_data[8*3 +: 8] = 8'hC3;
    req = 4'b1000;
    observe(1'b1, 1'b0, o);
    checks++; if (o.ack_or !== 4'b1000 || o.ack_cnt != 1 || o.gid !== GW'(3))
      begin errors++; $display("FAIL rmid_after got ack=%b x%0d id=%0d want 1000 x1 id=3", o.ack_or, o.ack_cnt, o.gid); end
    checks++; if (o.data !== 8'hC3) begin errors++; $display("FAIL rmid_data got %h want c3", o.data); end
    last_g = 3;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_single();
    test_guard_pulse();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
